// File: rtl/cpu_defs.sv
// Shared CPU definitions: access-width masks and the data-memory controller
// state encoding.
package cpu_defs;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  // True when the mask encodes one of the three legal access widths.
  function automatic logic mask_ok(input logic [3:0] m);
    return (m == MASK_B) || (m == MASK_H) || (m == MASK_W);
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering between the 32-bit core view and the SRAM word.
// Store side: byte enables and lane-replicated write data.
// Load side: shift the addressed bytes down and zero-extend to the load width.
module dmem_lane
  import cpu_defs::*;
(
  input  logic [3:0]  wmask,
  input  logic [1:0]  woff,
  input  logic [31:0] wdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [31:0] rdata_raw,
  input  logic [1:0]  roff,
  input  logic [3:0]  rmask,
  output logic [31:0] rdata_out
);

  logic [31:0] rdata_shift;

  // Store lanes: enables follow the byte offset, data is copied into every lane
  // so the SRAM only needs the enables to pick the right bytes.
  always_comb begin
    be = wmask << woff;
    case (wmask)
      MASK_B:  wdata_rep = {4{wdata_in[7:0]}};
      MASK_H:  wdata_rep = {2{wdata_in[15:0]}};
      default: wdata_rep = wdata_in;
    endcase
  end

  // Load lanes: right-align the addressed bytes, then clear lanes above the width.
  always_comb begin
    rdata_shift = rdata_raw >> {roff, 3'b000};
    rdata_out   = rdata_shift & {{8{rmask[3]}}, {8{rmask[2]}},
                                 {8{rmask[1]}}, {8{rmask[0]}}};
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller between the MEM stage and a synchronous SRAM.
// Stores are posted in the request cycle; loads stall the core for the SRAM
// read latency plus one capture cycle and return zero-extended data.
module dmem_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ce,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wmask,
  input  logic [3:0]        req_rmask,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_vld,
  output logic              addr_err,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_active;
  logic [3:0]  req_mask;
  logic        req_err;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  dmem_lane u_lane (
    .wmask     (req_wmask),
    .woff      (req_addr[1:0]),
    .wdata_in  (req_wdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_raw (sram_rdata),
    .roff      (off_q),
    .rmask     (rmask_q),
    .rdata_out (lane_rdata)
  );

  // Request qualification: malformed, misaligned or out-of-range requests are rejected.
  always_comb begin
    req_active = req_ce & (req_rd | req_wr);
    req_mask   = req_rd ? req_rmask : req_wmask;
    req_err    = (req_rd & req_wr)
               | ~mask_ok(req_mask)
               | ((req_mask == MASK_H) & req_addr[0])
               | ((req_mask == MASK_W) & (|req_addr[1:0]))
               | (|req_addr[31:ADDR_W+2]);
  end

  // Next-state and output decode; reset forces every output to its idle value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    rmask_d    = rmask_q;
    rdata_d    = rdata_q;
    stall      = 1'b0;
    rdata_vld  = 1'b0;
    addr_err   = 1'b0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_be    = '0;
    sram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req_active) begin
          if (req_err) begin
            addr_err = 1'b1;
          end else if (req_wr) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = req_addr[ADDR_W+1:2];
            sram_be    = lane_be;
            sram_wdata = lane_wdata;
          end else begin
            sram_ce   = 1'b1;
            stall     = 1'b1;
            sram_addr = req_addr[ADDR_W+1:2];
            off_d     = req_addr[1:0];
            rmask_d   = req_rmask;
            cnt_d     = 3'(READ_LAT - 1);
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (cnt_q == 3'd0) begin
          rdata_d = lane_rdata;
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_DONE: begin
        rdata_vld = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stall      = 1'b0;
      rdata_vld  = 1'b0;
      addr_err   = 1'b0;
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_be    = '0;
      sram_wdata = '0;
    end
  end

  // Control state, latency counter and returned load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Load request latch: lane offset and width captured when the load is issued.
  always_ff @(posedge clk) begin
    off_q   <= off_d;
    rmask_q <= rmask_d;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (read latency 1 and 3), each with its own
// SRAM model, checked against a byte-addressed reference memory.
module tb_dmem_ctrl;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b0;
  always #5 clk = ~clk;

  logic        req_ce [2];
  logic        req_rd [2];
  logic        req_wr [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic [3:0]  req_rmask [2];
  logic        stall [2];
  logic [31:0] rdata [2];
  logic        rdata_vld [2];
  logic        addr_err [2];
  logic        sram_ce [2];
  logic        sram_we [2];
  logic [AW-1:0] sram_addr [2];
  logic [3:0]  sram_be [2];
  logic [31:0] sram_wdata [2];
  logic [31:0] sram_rdata [2];

  logic [31:0] smem [2][1024];
  logic [31:0] pipe [2][3];
  logic [7:0]  ref_mem [2][4096];
  logic [31:0] last_rdata [2];

  int n_cmp = 0;
  int n_fail = 0;

  dmem_ctrl #(.ADDR_W(AW), .READ_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_ce(req_ce[0]), .req_rd(req_rd[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .req_rmask(req_rmask[0]), .stall(stall[0]), .rdata(rdata[0]), .rdata_vld(rdata_vld[0]),
    .addr_err(addr_err[0]), .sram_ce(sram_ce[0]), .sram_we(sram_we[0]),
    .sram_addr(sram_addr[0]), .sram_be(sram_be[0]), .sram_wdata(sram_wdata[0]),
    .sram_rdata(sram_rdata[0]));

  dmem_ctrl #(.ADDR_W(AW), .READ_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst), .req_ce(req_ce[1]), .req_rd(req_rd[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .req_rmask(req_rmask[1]), .stall(stall[1]), .rdata(rdata[1]), .rdata_vld(rdata_vld[1]),
    .addr_err(addr_err[1]), .sram_ce(sram_ce[1]), .sram_we(sram_we[1]),
    .sram_addr(sram_addr[1]), .sram_be(sram_be[1]), .sram_wdata(sram_wdata[1]),
    .sram_rdata(sram_rdata[1]));

  function automatic logic [31:0] seed(input int d, input int i);
    return (32'(i) * 32'h9E37_79B1) ^ (32'(d + 1) * 32'h85EB_CA6B);
  endfunction

  // SRAM models: byte-enabled writes, reads delivered after the instance's latency.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_init) begin
        for (int i = 0; i < 1024; i++) smem[d][i] <= seed(d, i);
      end else if (sram_ce[d] && sram_we[d]) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[d][b]) smem[d][sram_addr[d]][8*b +: 8] <= sram_wdata[d][8*b +: 8];
      end
      pipe[d][0] <= (sram_ce[d] && !sram_we[d]) ? smem[d][sram_addr[d]] : 32'hDEAD_BEEF;
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign sram_rdata[0] = pipe[0][0];
  assign sram_rdata[1] = pipe[1][2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int msize(input logic [3:0] m);
    if (m == 4'b0001) return 1;
    if (m == 4'b0011) return 2;
    if (m == 4'b1111) return 4;
    return 0;
  endfunction

  function automatic bit exp_err(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [3:0] m);
    int sz;
    sz = msize(m);
    if (rd && wr) return 1;
    if (sz == 0) return 1;
    if ((a % sz) != 0) return 1;
    if (a >= 32'(4 << AW)) return 1;
    return 0;
  endfunction

  task automatic drive_idle(input int d);
    req_ce[d] = 1'b0; req_rd[d] = 1'b0; req_wr[d] = 1'b0;
    req_addr[d] = '0; req_wdata[d] = '0; req_wmask[d] = '0; req_rmask[d] = '0;
  endtask

  task automatic do_store(input int d, input logic [31:0] a, input logic [31:0] w,
                          input logic [3:0] m, input bit rd_too);
    bit e;
    int sz, off;
    logic [3:0] ebe;
    logic [31:0] ewd;
    @(negedge clk);
    req_ce[d] = 1; req_wr[d] = 1; req_rd[d] = rd_too; req_addr[d] = a;
    req_wdata[d] = w; req_wmask[d] = m; req_rmask[d] = m;
    #1;
    e = exp_err(rd_too, 1'b1, a, m);
    n_cmp++;
    if ({stall[d], addr_err[d], sram_ce[d], rdata_vld[d]} !== {1'b0, e, !e, 1'b0}) begin
      n_fail++;
      $display("FAIL store_ctl d=%0d addr=%h mask=%b got stall/err/ce/vld=%b exp=%b", d, a, m,
               {stall[d], addr_err[d], sram_ce[d], rdata_vld[d]}, {1'b0, e, !e, 1'b0});
    end
    if (!e) begin
      sz = msize(m);
      off = int'(a % 4);
      ebe = '0;
      for (int i = 0; i < sz; i++) ebe[off + i] = 1'b1;
      ewd = (sz == 1) ? {4{w[7:0]}} : (sz == 2) ? {2{w[15:0]}} : w;
      n_cmp++;
      if ({sram_we[d], sram_addr[d], sram_be[d], sram_wdata[d]} !== {1'b1, AW'(a >> 2), ebe, ewd}) begin
        n_fail++;
        $display("FAIL store_bus d=%0d addr=%h got we=%b a=%h be=%b wd=%h exp a=%h be=%b wd=%h",
                 d, a, sram_we[d], sram_addr[d], sram_be[d], sram_wdata[d], AW'(a >> 2), ebe, ewd);
      end
      for (int i = 0; i < sz; i++) ref_mem[d][a + i] = w[8*i +: 8];
    end
    @(negedge clk);
    drive_idle(d);
  endtask

  task automatic do_load(input int d, input logic [31:0] a, input logic [3:0] m,
                         input bit wr_too, input bit then_store,
                         input logic [31:0] sa, input logic [31:0] sw);
    bit e;
    int sz;
    logic [31:0] ev;
    @(negedge clk);
    req_ce[d] = 1; req_rd[d] = 1; req_wr[d] = wr_too; req_addr[d] = a;
    req_rmask[d] = m; req_wmask[d] = m; req_wdata[d] = $urandom();
    #1;
    e = exp_err(1'b1, wr_too, a, m);
    if (e) begin
      n_cmp++;
      if ({stall[d], addr_err[d], sram_ce[d], rdata_vld[d], rdata[d]} !==
          {4'b0100, last_rdata[d]}) begin
        n_fail++;
        $display("FAIL load_err d=%0d addr=%h mask=%b got s/e/ce/v=%b rdata=%h exp 0100 rdata=%h",
                 d, a, m, {stall[d], addr_err[d], sram_ce[d], rdata_vld[d]}, rdata[d], last_rdata[d]);
      end
      @(negedge clk);
      drive_idle(d);
      return;
    end
    sz = msize(m);
    ev = '0;
    for (int i = 0; i < sz; i++) ev = ev | (32'(ref_mem[d][a + i]) << (8 * i));
    n_cmp++;
    if ({stall[d], addr_err[d], sram_ce[d], sram_we[d], rdata_vld[d], sram_addr[d]} !==
        {5'b10100, AW'(a >> 2)}) begin
      n_fail++;
      $display("FAIL load_issue d=%0d addr=%h got s/e/ce/we/v=%b sa=%h exp 10100 sa=%h", d, a,
               {stall[d], addr_err[d], sram_ce[d], sram_we[d], rdata_vld[d]}, sram_addr[d], AW'(a >> 2));
    end
    for (int c = 1; c <= lat(d); c++) begin
      @(negedge clk);
      req_addr[d] = $urandom(); req_rmask[d] = 4'($urandom());
      #1;
      n_cmp++;
      if ({stall[d], sram_ce[d], rdata_vld[d], addr_err[d]} !== 4'b1000) begin
        n_fail++;
        $display("FAIL load_wait d=%0d cyc=%0d got s/ce/v/e=%b exp 1000", d, c,
                 {stall[d], sram_ce[d], rdata_vld[d], addr_err[d]});
      end
    end
    @(negedge clk);
    if (then_store) begin
      req_rd[d] = 0; req_wr[d] = 1; req_addr[d] = sa; req_wdata[d] = sw; req_wmask[d] = 4'b1111;
    end else begin
      req_addr[d] = a; req_rmask[d] = m;
    end
    #1;
    n_cmp++;
    if ({stall[d], sram_ce[d], rdata_vld[d], addr_err[d], rdata[d]} !== {4'b0010, ev}) begin
      n_fail++;
      $display("FAIL load_done d=%0d addr=%h mask=%b got s/ce/v/e=%b rdata=%h exp 0010 rdata=%h",
               d, a, m, {stall[d], sram_ce[d], rdata_vld[d], addr_err[d]}, rdata[d], ev);
    end
    last_rdata[d] = ev;
    if (then_store) begin
      do_store(d, sa, sw, 4'b1111, 1'b0);
    end else begin
      @(negedge clk);
      drive_idle(d);
      #1;
      n_cmp++;
      if ({rdata_vld[d], stall[d], rdata[d]} !== {2'b00, ev}) begin
        n_fail++;
        $display("FAIL load_hold d=%0d got v/s=%b rdata=%h exp 00 rdata=%h", d,
                 {rdata_vld[d], stall[d]}, rdata[d], ev);
      end
    end
  endtask

  task automatic do_nop(input int d);
    @(negedge clk);
    req_ce[d] = 1; req_rd[d] = 0; req_wr[d] = 0; req_addr[d] = 32'hFFFF_FFFF; req_wmask[d] = 4'b0101;
    #1;
    n_cmp++;
    if ({stall[d], addr_err[d], sram_ce[d], rdata_vld[d]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL nop d=%0d got s/e/ce/v=%b exp 0000", d,
               {stall[d], addr_err[d], sram_ce[d], rdata_vld[d]});
    end
    @(negedge clk);
    drive_idle(d);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      last_rdata[d] = '0;
      for (int i = 0; i < 1024; i++)
        for (int b = 0; b < 4; b++) ref_mem[d][4*i + b] = seed(d, i) >> (8 * b);
    end
    rst = 1; mem_init = 1;
    repeat (3) @(negedge clk);
    rst = 0; mem_init = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({stall[d], rdata_vld[d], addr_err[d], sram_ce[d], sram_we[d], rdata[d], sram_addr[d],
           sram_be[d], sram_wdata[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset d=%0d got s/v/e/ce/we=%b rdata=%h sa=%h be=%b wd=%h exp all zero", d,
                 {stall[d], rdata_vld[d], addr_err[d], sram_ce[d], sram_we[d]}, rdata[d],
                 sram_addr[d], sram_be[d], sram_wdata[d]);
      end
    end
  endtask

  task automatic test_store_byte();
    do_store(0, 32'h005, 32'h0000_00AB, 4'b0001, 1'b0);
    do_store(1, 32'h00E, 32'h0000_BEEF, 4'b0011, 1'b0);
  endtask

  task automatic test_load_half();
    do_store(0, 32'h004, 32'h1234_5678, 4'b1111, 1'b0);
    do_load(0, 32'h006, 4'b0011, 1'b0, 1'b0, 0, 0);
    do_load(0, 32'h005, 4'b0001, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_load_word();
    do_load(1, 32'h010, 4'b1111, 1'b0, 1'b0, 0, 0);
    do_load(1, 32'h00F, 4'b0001, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_errors();
    for (int d = 0; d < 2; d++) begin
      do_load(d, 32'h002, 4'b1111, 1'b0, 1'b0, 0, 0);
      do_load(d, 32'h000, 4'b1111, 1'b1, 1'b0, 0, 0);
      do_store(d, 32'h003, 32'h1111_2222, 4'b0011, 1'b0);
      do_store(d, 32'h008, 32'h3333_4444, 4'b0111, 1'b0);
      do_store(d, 32'h008, 32'h5555_6666, 4'b1111, 1'b1);
    end
  endtask

  task automatic test_range();
    do_load(0, 32'h1000, 4'b1111, 1'b0, 1'b0, 0, 0);
    do_store(0, 32'h1000, 32'hCAFE_F00D, 4'b1111, 1'b0);
    do_store(0, 32'h8000_0FFC, 32'hCAFE_F00D, 4'b1111, 1'b0);
    do_store(0, 32'hFFC, 32'hA5A5_5A5A, 4'b1111, 1'b0);
    do_load(0, 32'hFFC, 4'b1111, 1'b0, 1'b0, 0, 0);
    do_load(1, 32'hFFF, 4'b0001, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    req_ce[1] = 1; req_rd[1] = 1; req_wr[1] = 0; req_addr[1] = 32'h020; req_rmask[1] = 4'b1111;
    @(negedge clk);
    rst = 1;
    drive_idle(1);
    @(negedge clk);
    rst = 0;
    last_rdata[1] = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if ({stall[1], rdata_vld[1], sram_ce[1], rdata[1]} !== {3'b000, 32'h0}) begin
        n_fail++;
        $display("FAIL rst_abort cyc=%0d got s/v/ce=%b rdata=%h exp 000 rdata=0", c,
                 {stall[1], rdata_vld[1], sram_ce[1]}, rdata[1]);
      end
      @(negedge clk);
    end
    do_store(1, 32'h020, 32'h0BAD_F00D, 4'b1111, 1'b0);
    do_load(1, 32'h020, 4'b1111, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      do_load(d, 32'h040, 4'b1111, 1'b0, 1'b1, 32'h040, 32'h7654_3210 + 32'(d));
      do_load(d, 32'h042, 4'b0011, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_random(input int d, input int n);
    logic [3:0] m;
    logic [31:0] a;
    int sz;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 7))
        0, 1:    m = 4'b0001;
        2, 3:    m = 4'b0011;
        6:       m = 4'($urandom());
        default: m = 4'b1111;
      endcase
      sz = (msize(m) == 0) ? 1 : msize(m);
      case ($urandom_range(0, 9))
        0:       a = $urandom() | 32'h0000_1000;
        1:       a = 32'($urandom_range(0, 4095));
        default: a = 32'($urandom_range(0, 4095)) & ~32'(sz - 1);
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_store(d, a, $urandom(), m, 1'b0);
        8:          do_load(d, a, m, 1'b1, 1'b0, 0, 0);
        9:          do_nop(d);
        default:    do_load(d, a, m, 1'b0, 1'b0, 0, 0);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_load_word();
    test_errors();
    test_range();
    test_reset_mid_load();
    test_back_to_back();
    test_random(0, 120);
    test_random(1, 120);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
